ram_burst_ctrl: RTL and testbench

- Initiator-side controller for the single-port 256x32 synchronous RAM (ports: addr, rw, clk, din, dout; rw=1 means write).
- Accepts burst commands on a valid/ready interface and streams write data in over valid/ready.
- Issues one RAM access per cycle at sequential addresses that wrap modulo 256.
- Returns read data on a registered stream. Replaces ad-hoc address/rw sequencing in front of the RAM.

---
 rtl/ram_burst_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ram_burst_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: initiator-side burst controller for a single-port synchronous RAM.
// Takes burst commands over valid/ready, streams write beats into the RAM one
// per accepted beat, issues back-to-back read addresses and returns the read
// data on a registered stream. Addresses wrap modulo 2^AW.
//
// Ports:
//   clk, rst_n                 system clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_write/addr/len         burst direction, start address, beats-1
//   wr_valid/wr_ready/wr_data  write beat stream (ready only in WR)
//   rd_valid/rd_data/rd_last   registered read beat stream, no backpressure
//   busy                       controller not in IDLE
//   ram_addr/ram_rw/ram_din    registered RAM request
//   ram_dout                   RAM read data, valid READ_LAT edges after address launch
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a command; RAM held in read mode
// WR    | accepting write beats, one RAM write per accepted beat
// RD    | launching one read address per cycle
// DRAIN | all reads launched; waiting for outstanding tags to return
module ram_burst_ctrl #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rw,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_e;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [AW-1:0]       cur_q, cur_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       ram_addr_q, ram_addr_d;
  logic                ram_rw_q, ram_rw_d;
  logic [DW-1:0]       ram_din_q, ram_din_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q, rd_last_d;
  logic [DW-1:0]       rd_data_q, rd_data_d;
  // Read tag pipeline: bit 0 is written at address launch, the MSB exits
  // on the edge where ram_dout is sampled.
  logic [READ_LAT-1:0] tag_v_q, tag_v_d;
  logic [READ_LAT-1:0] tag_l_q, tag_l_d;

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_rw_d   = 1'b0;
    ram_din_d  = ram_din_q;
    rd_data_d  = rd_data_q;
    tag_v_d    = tag_v_q << 1;
    tag_l_d    = tag_l_q << 1;

    rd_valid_d = tag_v_q[READ_LAT-1];
    rd_last_d  = tag_v_q[READ_LAT-1] & tag_l_q[READ_LAT-1];
    if (tag_v_q[READ_LAT-1]) begin
      rd_data_d = ram_dout;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_d   = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_write ? WR : RD;
        end
      end
      WR: begin
        if (wr_valid) begin
          ram_rw_d   = 1'b1;
          ram_addr_d = cur_q;
          ram_din_d  = wr_data;
          cur_d      = cur_q + ONE;
          cnt_d      = cnt_q - ONE;
          if (cnt_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      RD: begin
        ram_addr_d = cur_q;
        cur_d      = cur_q + ONE;
        cnt_d      = cnt_q - ONE;
        tag_v_d[0] = 1'b1;
        tag_l_d[0] = (cnt_q == '0);
        if (cnt_q == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave once the last outstanding tag exits on this edge.
        if (tag_v_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_q      <= '0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      ram_rw_q   <= 1'b0;
      ram_din_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      tag_v_q    <= '0;
      tag_l_q    <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_rw_q   <= ram_rw_d;
      ram_din_q  <= ram_din_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      tag_v_q    <= tag_v_d;
      tag_l_q    <= tag_l_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WR);
  assign busy      = (state_q != IDLE);
  assign ram_addr  = ram_addr_q;
  assign ram_rw    = ram_rw_q;
  assign ram_din   = ram_din_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: directed bench for ram_burst_ctrl. Instance u_dut1 uses
// READ_LAT=1 with a RAM model whose read data follows ram_addr; instance
// u_dut3 uses READ_LAT=3 with a two-stage address delay in its RAM model.
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  // READ_LAT=1 instance
  logic        cmd_valid1 = 0, cmd_ready1, cmd_write1 = 0;
  logic [7:0]  cmd_addr1 = 0, cmd_len1 = 0;
  logic        wr_valid1 = 0, wr_ready1;
  logic [31:0] wr_data1 = 0;
  logic        rd_valid1, rd_last1, busy1, ram_rw1;
  logic [31:0] rd_data1, ram_din1, ram_dout1;
  logic [7:0]  ram_addr1;
  logic [31:0] mem1 [256];

  // READ_LAT=3 instance
  logic        cmd_valid3 = 0, cmd_ready3, cmd_write3 = 0;
  logic [7:0]  cmd_addr3 = 0, cmd_len3 = 0;
  logic        wr_valid3 = 0, wr_ready3;
  logic [31:0] wr_data3 = 0;
  logic        rd_valid3, rd_last3, busy3, ram_rw3;
  logic [31:0] rd_data3, ram_din3, ram_dout3;
  logic [7:0]  ram_addr3, a3_d1, a3_d2;
  logic [31:0] mem3 [256];

  logic [7:0]  wr_a[$];
  logic [31:0] wr_d[$];
  logic [31:0] rd_q[$];
  logic        rd_l[$];
  int          rd_c[$];
  int          acc_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_burst_ctrl #(.AW(8), .DW(32), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write1),
    .cmd_addr(cmd_addr1), .cmd_len(cmd_len1),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_data(wr_data1),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_last(rd_last1),
    .busy(busy1), .ram_addr(ram_addr1), .ram_rw(ram_rw1),
    .ram_din(ram_din1), .ram_dout(ram_dout1)
  );

  ram_burst_ctrl #(.AW(8), .DW(32), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write3),
    .cmd_addr(cmd_addr3), .cmd_len(cmd_len3),
    .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_data(wr_data3),
    .rd_valid(rd_valid3), .rd_data(rd_data3), .rd_last(rd_last3),
    .busy(busy3), .ram_addr(ram_addr3), .ram_rw(ram_rw3),
    .ram_din(ram_din3), .ram_dout(ram_dout3)
  );

  // RAM models
  always @(posedge clk) if (ram_rw1) mem1[ram_addr1] <= ram_din1;
  assign ram_dout1 = mem1[ram_addr1];

  always @(posedge clk) begin
    a3_d1 <= ram_addr3;
    a3_d2 <= a3_d1;
  end
  assign ram_dout3 = mem3[a3_d2];

  // Monitors for the READ_LAT=1 instance, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_rw1) begin
      wr_a.push_back(ram_addr1);
      wr_d.push_back(ram_din1);
    end
    if (rd_valid1) begin
      rd_q.push_back(rd_data1);
      rd_l.push_back(rd_last1);
      rd_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input logic [7:0] a, input int i,
                                       input logic [31:0] base, input bit full);
    return full ? ({24'h0, a} ^ 32'h5A5A5A5A) : base + 32'(i);
  endfunction

  task automatic issue_cmd(input bit w, input logic [7:0] a, input logic [7:0] l);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready1) chk("cmd_ready_wait", {31'h0, cmd_ready1}, 32'h1);
    cmd_valid1 = 1'b1;
    cmd_write1 = w;
    cmd_addr1  = a;
    cmd_len1   = l;
    @(posedge clk);
    #1 cmd_valid1 = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wr_burst(input logic [7:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input bit bubble, input bit full);
    int bad = 0;
    logic [7:0] a;
    @(posedge clk);
    #1 wr_a.delete();
    wr_d.delete();
    issue_cmd(1'b1, addr, len);
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      if (bubble && i > 0) begin
        wr_valid1 = 1'b0;
        if (cmd_ready1) bad++;
        @(negedge clk);
      end
      if (cmd_ready1 || !wr_ready1) bad++;
      a = addr + 8'(i);
      wr_valid1 = 1'b1;
      wr_data1  = beat(a, i, base, full);
      @(posedge clk);
    end
    @(negedge clk);
    wr_valid1 = 1'b0;
    chk("wr_cmd_ready_after_last", {31'h0, cmd_ready1}, 32'h1);
    chk("wr_ready_flags_during", 32'(bad), 32'h0);
    @(negedge clk);
    chk("wr_rw_back_to_idle", {31'h0, ram_rw1}, 32'h0);
    chk("wr_count", 32'(wr_a.size()), 32'(len) + 1);
    for (int i = 0; i < wr_a.size(); i++) begin
      a = addr + 8'(i);
      chk("wr_addr", {24'h0, wr_a[i]}, {24'h0, a});
      chk("wr_data", wr_d[i], beat(a, i, base, full));
    end
  endtask

  task automatic rd_burst(input logic [7:0] addr, input logic [7:0] len,
                          input logic [31:0] base, input bit full);
    int nlast = 0;
    logic [7:0] a;
    @(posedge clk);
    #1 rd_q.delete();
    rd_l.delete();
    rd_c.delete();
    issue_cmd(1'b0, addr, len);
    repeat (int'(len) + 12) @(negedge clk);
    chk("rd_count", 32'(rd_q.size()), 32'(len) + 1);
    chk("rd_busy_end", {31'h0, busy1}, 32'h0);
    if (rd_q.size() > 0) begin
      chk("rd_first_latency", 32'(rd_c[0] - acc_cyc), 32'h2);
      chk("rd_back_to_back", 32'(rd_c[rd_c.size()-1] - rd_c[0]), 32'(len));
      chk("rd_last_on_final", {31'h0, rd_l[rd_l.size()-1]}, 32'h1);
    end
    for (int i = 0; i < rd_q.size(); i++) begin
      a = addr + 8'(i);
      chk("rd_data", rd_q[i], beat(a, i, base, full));
      if (rd_l[i]) nlast++;
    end
    chk("rd_last_count", 32'(nlast), 32'h1);
  endtask

  initial begin
    int e0, d, acc2, nrv, busy_bad;
    int rv_d [2];
    logic [31:0] rv_data [2];
    logic rv_last [2];

    mem3[8'h33] = 32'hDEADBEEF;
    mem3[8'h34] = 32'h12345678;

    // Reset values
    #12;
    chk("rst_cmd_ready", {31'h0, cmd_ready1}, 32'h1);
    chk("rst_busy", {31'h0, busy1}, 32'h0);
    chk("rst_wr_ready", {31'h0, wr_ready1}, 32'h0);
    chk("rst_rd_valid", {31'h0, rd_valid1}, 32'h0);
    chk("rst_rd_last", {31'h0, rd_last1}, 32'h0);
    chk("rst_rd_data", rd_data1, 32'h0);
    chk("rst_ram_rw", {31'h0, ram_rw1}, 32'h0);
    chk("rst_ram_addr", {24'h0, ram_addr1}, 32'h0);
    chk("rst_ram_din", ram_din1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // wr_valid in IDLE is ignored
    @(posedge clk);
    #1 wr_a.delete();
    wr_d.delete();
    @(negedge clk);
    wr_valid1 = 1'b1;
    wr_data1  = 32'hFFFF0000;
    chk("idle_wr_ready", {31'h0, wr_ready1}, 32'h0);
    repeat (2) @(negedge clk);
    wr_valid1 = 1'b0;
    chk("idle_no_write", 32'(wr_a.size()), 32'h0);

    // Reset in the middle of a write burst
    issue_cmd(1'b1, 8'h40, 8'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_valid1 = 1'b1;
      wr_data1  = 32'h77 + 32'(i);
      @(posedge clk);
    end
    @(negedge clk);
    wr_valid1 = 1'b0;
    chk("pre_rst_rw", {31'h0, ram_rw1}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rw", {31'h0, ram_rw1}, 32'h0);
    chk("mid_rst_cmd_ready", {31'h0, cmd_ready1}, 32'h1);
    chk("mid_rst_busy", {31'h0, busy1}, 32'h0);
    chk("mid_rst_ram_addr", {24'h0, ram_addr1}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write / readback
    wr_burst(8'h10, 8'd3, 32'hA0, 1'b0, 1'b0);
    rd_burst(8'h10, 8'd3, 32'hA0, 1'b0);

    // Bubbled write
    wr_burst(8'h20, 8'd7, 32'hB0, 1'b1, 1'b0);
    rd_burst(8'h20, 8'd7, 32'hB0, 1'b0);

    // Wrap across 0xFF
    wr_burst(8'hFE, 8'd3, 32'hC0, 1'b0, 1'b0);
    rd_burst(8'hFE, 8'd3, 32'hC0, 1'b0);

    // Full range
    wr_burst(8'h00, 8'd255, 32'h0, 1'b0, 1'b1);
    rd_burst(8'h00, 8'd255, 32'h0, 1'b1);

    // READ_LAT=3: single-beat read, second command held through DRAIN
    nrv = 0;
    acc2 = 0;
    busy_bad = 0;
    rv_d[0] = 0; rv_d[1] = 0;
    rv_data[0] = 0; rv_data[1] = 0;
    rv_last[0] = 0; rv_last[1] = 0;
    @(negedge clk);
    cmd_valid3 = 1'b1;
    cmd_write3 = 1'b0;
    cmd_addr3  = 8'h33;
    cmd_len3   = 8'd0;
    @(posedge clk);
    #1 e0 = cyc;
    cmd_addr3 = 8'h34;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      d = cyc - e0;
      if (d >= 1 && d <= 3 && (!busy3 || cmd_ready3)) busy_bad++;
      if (rd_valid3 && nrv < 2) begin
        rv_d[nrv]    = d;
        rv_data[nrv] = rd_data3;
        rv_last[nrv] = rd_last3;
        nrv++;
      end
      if (acc2 != 0 && d >= acc2) cmd_valid3 = 1'b0;
      if (cmd_ready3 && cmd_valid3 && acc2 == 0) acc2 = d + 1;
    end
    chk("l3_busy_through_drain", 32'(busy_bad), 32'h0);
    chk("l3_rd_count", 32'(nrv), 32'h2);
    chk("l3_first_latency", 32'(rv_d[0]), 32'h4);
    chk("l3_first_data", rv_data[0], 32'hDEADBEEF);
    chk("l3_first_last", {31'h0, rv_last[0]}, 32'h1);
    chk("l3_second_accept", 32'(acc2), 32'h5);
    chk("l3_second_latency", 32'(rv_d[1]), 32'h9);
    chk("l3_second_data", rv_data[1], 32'h12345678);
    chk("l3_second_last", {31'h0, rv_last[1]}, 32'h1);
    chk("l3_never_writes", {31'h0, ram_rw3}, 32'h0);
    chk("l3_ram_din", ram_din3, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
